digital_input_filter: RTL
=========================

# digital_input_filter

Debounce and edge-event stage for PLC digital inputs. It sits directly downstream of the per-pin `digital_io` instances and consumes their `data_out` bits. Each channel is resynchronised, then debounced on a sample strobe. The block publishes a clean logic level plus sticky rising/falling-edge pending flags and a single interrupt request toward the PLC core.

## Interface
Parameters:
- `CHANNELS`, 8: number of input channels.
- `DEBOUNCE`, 4: consecutive disagreeing samples needed to change the level. Legal range 1..255.
- `CNT_W` is a localparam, not overridable: `$clog2(DEBOUNCE+1)`.

Ports:
- `clk`  in  1  system clock; single clock domain.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `sample_en`  in  1  sampling strobe; the same strobe that drives the `en` of the `digital_io` instances.
- `raw_in`  in  CHANNELS  input bits from the `digital_io` `data_out` ports.
- `rise_mask`  in  CHANNELS  per-channel enable for latching rising events.
- `fall_mask`  in  CHANNELS  per-channel enable for latching falling events.
- `clear`  in  CHANNELS  write-1-to-clear pulse; clears both pending flags of the channel.
- `level`  out  CHANNELS  debounced level.
- `rise_pend`  out  CHANNELS  sticky rising-event flags.
- `fall_pend`  out  CHANNELS  sticky falling-event flags.
- `irq`  out  1  OR of all pending flags.

## Operation
- **Synchroniser.** `raw_in` passes through a 2-flop synchroniser clocked every `clk`, not gated by `sample_en`. Its output is `s`.
- **Debounce, per channel, only on cycles with `sample_en`=1:**
  - `s == level`: `cnt <= 0`.
  - `s != level` and `cnt+1 < DEBOUNCE`: `cnt <= cnt+1`.
  - `s != level` and `cnt+1 == DEBOUNCE`: `level <= s`, `cnt <= 0`, and a one-cycle internal `chg` pulse is raised.
- **Hold.** With `sample_en`=0, `cnt` and `level` hold.
- **Counter range.** `cnt` never exceeds `DEBOUNCE-1`, so no wrap is possible.
- **DEBOUNCE=1.** The level follows `s` on the first strobe where they differ.
- **Glitch rejection.** A disagreement shorter than `DEBOUNCE` consecutive strobes is discarded, because `cnt` returns to 0.
- **Events.**
  - `chg` with new level 1 sets `rise_pend[i]` if `rise_mask[i]`.
  - `chg` with new level 0 sets `fall_pend[i]` if `fall_mask[i]`.
  - The mask is sampled in the same cycle as `chg`.
  - With the mask bit clear, `level` still updates but no flag is set.
- **Clear.** `clear[i]` clears `rise_pend[i]` and `fall_pend[i]` at the next edge.
  - On the same edge, set beats clear per flag, so no event is lost. The other flag of that channel still clears.
- **irq.** `irq = |(rise_pend | fall_pend)`. It is combinational from flops only, so it is glitch-free.
- **Reset.** All of the following go to 0 asynchronously on `rst_n` low: sync flops, `cnt`, `level`, `rise_pend`, `fall_pend`, and therefore `irq`.
  - Reset mid-debounce discards the partial count.
  - The first level change after reset needs the full `DEBOUNCE` strobes.

## Timing
- **Latency with `sample_en` held high.** `raw_in` changes before edge 1; `level`, the pending flag and `irq` change on edge 2+`DEBOUNCE`.
- **Latency with a strobed `sample_en`.** 2 clocks of synchronisation, then `DEBOUNCE` strobes that all see the new `s`. The update occurs on the edge of the last strobe.
- **clear.** Takes effect 1 clock after assertion. `irq` falls in that same cycle if no other flag is pending.
- **Channel independence.** All channels are independent. Simultaneous events on several channels each latch in the same cycle.

## Structure
- **Shared package `plc_io_pkg`.** Holds `PLC_IO_CHANNELS` (8) and `PLC_DEBOUNCE_DEFAULT` (4), which are also used by the `digital_io` array wrapper.
- **Sub-module `debounce_channel`.** Contains one channel's synchroniser, counter and level register, with outputs `level` and `chg`. It is instantiated `CHANNELS` times in a generate loop.
- **Top level.** Mask, pending and `irq` logic stay in the top.

## Test plan
1. **Reset and power-up.** Hold `rst_n`=0 with `raw_in`=8'hFF: all outputs are 0. Release with `sample_en`=1, `rise_mask`=8'hFF, `DEBOUNCE`=4: `level`=8'hFF, `rise_pend`=8'hFF and `irq`=1 on the 6th edge after release, not earlier.
2. **Glitch reject.** `raw_in[0]` high for exactly 3 strobes, then low: `level[0]` stays 0, no pending flag, `irq`=0.
3. **Strobe gating.** `sample_en` pulsed every 10 clocks: `level[3]` changes on the 4th strobe after `s` flips, and holds between strobes.
4. **Mask.** `fall_mask`=0 with channel 1 falling: `level[1]` goes 0, `fall_pend[1]` stays 0, `irq` stays 0.
5. **Set/clear collision.** `rise_pend[2]`=1, then `clear[2]` pulsed on the same edge as a new fall `chg` on channel 2: after that edge `rise_pend[2]`=0 and `fall_pend[2]`=1.
6. **Asynchronous reset mid-debounce.** Assert `rst_n` low between edges after `cnt`=2: outputs go 0 without a clock edge. After release, the change needs 2+4 edges again.

Source files
------------

// File: rtl/plc_io_pkg.sv
// Shared constants for the PLC digital-input path (digital_io array and input filter).
`timescale 1ns/1ps
package plc_io_pkg;

  localparam int PLC_IO_CHANNELS      = 8;
  localparam int PLC_DEBOUNCE_DEFAULT = 4;

endpackage

// File: rtl/debounce_channel.sv
// One input channel: 2-flop resynchroniser, strobe-qualified debounce counter and level register.
`timescale 1ns/1ps
module debounce_channel #(
  parameter int DEBOUNCE = 4,
  parameter int CNT_W    = $clog2(DEBOUNCE + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sample_en,
  input  logic raw,
  output logic level,
  output logic chg
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE - 1);

  logic             sync_meta;
  logic             s;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_meta <= 1'b0;
      s         <= 1'b0;
    end else begin
      sync_meta <= raw;
      s         <= sync_meta;
    end
  end

  // chg marks the strobe on which level will flip, so the top can latch events on the same edge.
  assign chg = sample_en && (s != level) && (cnt == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      level <= 1'b0;
    end else if (sample_en) begin
      if (s == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        level <= s;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/digital_input_filter.sv
// Debounced PLC digital inputs with sticky rise/fall pending flags and a shared interrupt.
`timescale 1ns/1ps
module digital_input_filter
  import plc_io_pkg::*;
#(
  parameter int CHANNELS = PLC_IO_CHANNELS,
  parameter int DEBOUNCE = PLC_DEBOUNCE_DEFAULT
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                sample_en,
  input  logic [CHANNELS-1:0] raw_in,
  input  logic [CHANNELS-1:0] rise_mask,
  input  logic [CHANNELS-1:0] fall_mask,
  input  logic [CHANNELS-1:0] clear,
  output logic [CHANNELS-1:0] level,
  output logic [CHANNELS-1:0] rise_pend,
  output logic [CHANNELS-1:0] fall_pend,
  output logic                irq
);

  localparam int CNT_W = $clog2(DEBOUNCE + 1);

  logic [CHANNELS-1:0] chg;
  logic [CHANNELS-1:0] set_rise;
  logic [CHANNELS-1:0] set_fall;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    debounce_channel #(
      .DEBOUNCE (DEBOUNCE),
      .CNT_W    (CNT_W)
    ) u_ch (
      .clk       (clk),
      .rst_n     (rst_n),
      .sample_en (sample_en),
      .raw       (raw_in[i]),
      .level     (level[i]),
      .chg       (chg[i])
    );
  end

  // level still holds the old value while chg is high, so old 0 means a rising event.
  assign set_rise = chg & ~level & rise_mask;
  assign set_fall = chg &  level & fall_mask;

  // Set has priority over clear per flag so a colliding event is never lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rise_pend <= '0;
      fall_pend <= '0;
    end else begin
      rise_pend <= set_rise | (rise_pend & ~clear);
      fall_pend <= set_fall | (fall_pend & ~clear);
    end
  end

  assign irq = |(rise_pend | fall_pend);

endmodule
